// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width, tx feeder FSM states, FIFO depth helper.
// Used by uart_tx_fifo_ctrl (optional feature macro: UART_TX_FIFO_OVF_EN).
package uart_pkg;

    localparam int unsigned DBIT_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Host-write / uart_tx handshake bundle for uart_tx_fifo_ctrl.
// The overflow flag exists only when UART_TX_FIFO_OVF_EN is defined.
interface uart_tx_fifo_ctrl_if
    import uart_pkg::*;
#(
    parameter int unsigned DBIT = DBIT_DEFAULT
);

    logic            wr_en;
    logic [DBIT-1:0] wr_data;
    logic            full;
    logic            empty;
    logic            busy;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx_done_tick;
`ifdef UART_TX_FIFO_OVF_EN
    logic            overflow;

    modport master (
        output wr_en, wr_data, tx_done_tick,
        input  full, empty, busy, tx_start, din, overflow
    );
    modport slave (
        input  wr_en, wr_data, tx_done_tick,
        output full, empty, busy, tx_start, din, overflow
    );
`else
    modport master (
        output wr_en, wr_data, tx_done_tick,
        input  full, empty, busy, tx_start, din
    );
    modport slave (
        input  wr_en, wr_data, tx_done_tick,
        output full, empty, busy, tx_start, din
    );
`endif

endinterface

// File: rtl/uart_tx_fifo_ctrl_fifo.sv
// uart_fifo: synchronous register-array FIFO; full/empty are registered from the next count.
// Writes while full and reads while empty are ignored.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DBIT   = DBIT_DEFAULT,
    parameter int unsigned ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [DBIT-1:0] wr_data,
    input  logic            rd,
    output logic [DBIT-1:0] rd_data,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] count
);

    localparam int unsigned    DEPTH    = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_next;
    logic              full_q;
    logic              empty_q;
    logic              do_wr;
    logic              do_rd;

    assign do_wr = wr && !full_q;
    assign do_rd = rd && !empty_q;

    always_comb begin
        count_next = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_next = count_q + (ADDR_W+1)'(1);
            2'b01:   count_next = count_q - (ADDR_W+1)'(1);
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
            count_q <= count_next;
            full_q  <= (count_next == FULL_CNT);
            empty_q <= (count_next == '0);
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Feeds uart_tx from a host-written FIFO: pop, pulse tx_start, wait for tx_done_tick.
// Define UART_TX_FIFO_OVF_EN to add a sticky overflow flag for writes dropped while full.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DBIT   = DBIT_DEFAULT,
    parameter int unsigned ADDR_W = 4
) (
    input logic               clk,
    input logic               reset,
    uart_tx_fifo_ctrl_if.slave bus
);

    logic [DBIT-1:0] rd_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ADDR_W:0] fifo_count;
    logic            pop;
    logic [DBIT-1:0] din_q;
    state_t          state;
    state_t          state_next;

    // count and the registered empty flag always agree; count is used for the pop decision
    assign pop = (state == ST_IDLE) && (fifo_count != '0);

    uart_fifo #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd      (pop),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (pop) state_next = ST_START;
            ST_START: state_next = ST_WAIT;
            ST_WAIT:  if (bus.tx_done_tick) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)    din_q <= '0;
        else if (pop) din_q <= rd_data;
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (reset)                        overflow_q <= 1'b0;
        else if (bus.wr_en && fifo_full)  overflow_q <= 1'b1;
    end

    assign bus.overflow = overflow_q;
`endif

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.tx_start = (state == ST_START);
    assign bus.din      = din_q;

endmodule
